quadrature_decode_nch: RTL and testbench

Multi-channel quadrature encoder decoder, the parametrised successor to the single-channel counter.
- Per channel: synchronises asynchronous A/B inputs, rejects glitches shorter than a programmable stable time, decodes Gray-code steps into a wrapping up/down count, and flags illegal double-bit transitions.
- Sits between encoder input pins and the register/readout logic; one instance serves all encoders on the board.

---
 rtl/quadrature_decode_nch.sv | 208 ++++++++++++++++++++
 tb/tb_quadrature_decode_nch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_decode_nch.sv
// Multi-channel quadrature decoder: per-channel sync, glitch filter, Gray decode, wrapping count.
// Optional index support is compiled in with `define QDEC_INDEX_EN.

module qdec_filt #(
    parameter int W      = 2,
    parameter int FILTER = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc,
    output logic         acc_vld
);
    localparam int CW = $clog2(FILTER + 1);

    logic [W-1:0]  meta, sync, cand;
    logic [1:0]    vld_pipe;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          hit;

    // cnt_nxt is the run length of identical synchronised samples including this one
    always_comb begin
        cnt_nxt = CW'(1);
        if (sync == cand)
            cnt_nxt = (cnt == CW'(FILTER)) ? cnt : cnt + CW'(1);
        hit = vld_pipe[1] && (cnt_nxt == CW'(FILTER));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= '0;
            sync     <= '0;
            cand     <= '0;
            cnt      <= '0;
            vld_pipe <= '0;
            acc      <= '0;
            acc_vld  <= 1'b0;
        end else begin
            meta     <= din;
            sync     <= meta;
            // the filter ignores synchroniser contents left over from reset
            vld_pipe <= {vld_pipe[0], 1'b1};
            if (vld_pipe[1]) begin
                cand <= sync;
                cnt  <= cnt_nxt;
            end
            if (hit) begin
                acc     <= sync;
                acc_vld <= 1'b1;
            end
        end
    end
endmodule

module qdec_chan #(
    parameter int WIDTH  = 16,
    parameter int FILTER = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
`ifdef QDEC_INDEX_EN
    input  logic             idx,
    output logic             idx_seen,
`endif
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             dir,
    output logic             err
);
    logic [1:0] acc_ab, prev_ab, diff;
    logic       ab_vld, prev_vld;
    logic       up, dn, bad, idx_rise;

    qdec_filt #(.W(2), .FILTER(FILTER)) u_filt_ab (
        .clk(clk), .rst(rst), .din({a, b}), .acc(acc_ab), .acc_vld(ab_vld)
    );

`ifdef QDEC_INDEX_EN
    logic acc_idx, idx_vld, prev_idx, prev_idx_vld;

    qdec_filt #(.W(1), .FILTER(FILTER)) u_filt_idx (
        .clk(clk), .rst(rst), .din(idx), .acc(acc_idx), .acc_vld(idx_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_idx     <= 1'b0;
            prev_idx_vld <= 1'b0;
        end else begin
            prev_idx     <= acc_idx;
            prev_idx_vld <= idx_vld;
        end
    end

    assign idx_rise = idx_vld && prev_idx_vld && acc_idx && !prev_idx;
`else
    assign idx_rise = 1'b0;
`endif

    // position around the Gray cycle 00,01,11,10
    function automatic logic [1:0] gpos(input logic [1:0] s);
        case (s)
            2'b00:   gpos = 2'd0;
            2'b01:   gpos = 2'd1;
            2'b11:   gpos = 2'd2;
            default: gpos = 2'd3;
        endcase
    endfunction

    always_comb begin
        up   = 1'b0;
        dn   = 1'b0;
        bad  = 1'b0;
        diff = gpos(acc_ab) - gpos(prev_ab);
        if (ab_vld && prev_vld) begin
            case (diff)
                2'd1:    up  = 1'b1;
                2'd3:    dn  = 1'b1;
                2'd2:    bad = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ab  <= '0;
            prev_vld <= 1'b0;
            count    <= '0;
            step     <= 1'b0;
            dir      <= 1'b0;
            err      <= 1'b0;
`ifdef QDEC_INDEX_EN
            idx_seen <= 1'b0;
`endif
        end else begin
            prev_ab  <= acc_ab;
            prev_vld <= ab_vld;
            step     <= 1'b0;
            if (clr) begin
                count <= '0;
                err   <= 1'b0;
`ifdef QDEC_INDEX_EN
                idx_seen <= 1'b0;
`endif
            end else begin
                if (bad)
                    err <= 1'b1;
                if (idx_rise) begin
                    count <= '0;
`ifdef QDEC_INDEX_EN
                    idx_seen <= 1'b1;
`endif
                end else if (up) begin
                    count <= count + WIDTH'(1);
                    dir   <= 1'b1;
                    step  <= 1'b1;
                end else if (dn) begin
                    count <= count - WIDTH'(1);
                    dir   <= 1'b0;
                    step  <= 1'b1;
                end
            end
        end
    end
endmodule

module quadrature_decode_nch #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 16,
    parameter int FILTER   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       a,
    input  logic [CHANNELS-1:0]       b,
    input  logic [CHANNELS-1:0]       clr,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       step,
    output logic [CHANNELS-1:0]       dir,
    output logic [CHANNELS-1:0]       err
`ifdef QDEC_INDEX_EN
    ,
    input  logic [CHANNELS-1:0]       idx,
    output logic [CHANNELS-1:0]       idx_seen
`endif
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        qdec_chan #(.WIDTH(WIDTH), .FILTER(FILTER)) u_chan (
            .clk      (clk),
            .rst      (rst),
            .a        (a[i]),
            .b        (b[i]),
            .clr      (clr[i]),
`ifdef QDEC_INDEX_EN
            .idx      (idx[i]),
            .idx_seen (idx_seen[i]),
`endif
            .count    (count[i*WIDTH +: WIDTH]),
            .step     (step[i]),
            .dir      (dir[i]),
            .err      (err[i])
        );
    end
endmodule

// File: tb/tb_quadrature_decode_nch.sv
// Randomized bench for quadrature_decode_nch against a sample-history reference model.
module tb_quadrature_decode_nch;
    localparam int CH = 2;
    localparam int W  = 4;
    localparam int F  = 3;
    localparam int HN = 4096;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   a, b, clr;
    logic [CH*W-1:0] count;
    logic [CH-1:0]   step, dir, err;

    always #5 clk = ~clk;

    quadrature_decode_nch #(.CHANNELS(CH), .WIDTH(W), .FILTER(F)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
        .count(count), .step(step), .dir(dir), .err(err)
    );

    int tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // reference model: raw sample history since reset, plus architectural state
    int         n;
    logic [1:0] hist [CH][HN];
    logic [1:0] cur [CH];
    bit         primed [CH];
    int         mcount [CH];
    bit         mstep [CH], mdir [CH], merr [CH];

    function automatic int gp(input logic [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gv(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // a pair is accepted at edge e when the F latest synchronised samples
    // (raw samples e-2 .. e-F-1) exist since reset and are all equal
    function automatic bit accepted(input int ch, input int e, output logic [1:0] v);
        v = 2'b00;
        if (e - F - 1 < 1) return 0;
        v = hist[ch][e-2];
        for (int j = 3; j <= F + 1; j++)
            if (hist[ch][e-j] != v) return 0;
        return 1;
    endfunction

    task automatic model_edge();
        logic [1:0] v;
        int d;
        if (rst) begin
            n = 0;
            for (int c = 0; c < CH; c++) begin
                primed[c] = 0; mcount[c] = 0; mstep[c] = 0; mdir[c] = 0; merr[c] = 0;
            end
        end else begin
            n++;
            for (int c = 0; c < CH; c++) begin
                hist[c][n] = {a[c], b[c]};
                mstep[c] = 0;
                if (clr[c]) begin
                    mcount[c] = 0;
                    merr[c]   = 0;
                end
                if (accepted(c, n - 1, v)) begin
                    if (!primed[c]) begin
                        primed[c] = 1;
                    end else if (!clr[c]) begin
                        d = (gp(v) - gp(cur[c]) + 4) % 4;
                        if (d == 1) begin
                            mcount[c] = (mcount[c] + 1) % (1 << W);
                            mdir[c] = 1; mstep[c] = 1;
                        end else if (d == 3) begin
                            mcount[c] = (mcount[c] + (1 << W) - 1) % (1 << W);
                            mdir[c] = 0; mstep[c] = 1;
                        end else if (d == 2) begin
                            merr[c] = 1;
                        end
                    end
                    cur[c] = v;
                end
            end
        end
    endtask

    task automatic cycle(input logic [CH-1:0][1:0] ab, input logic [CH-1:0] c, input logic r);
        @(negedge clk);
        for (int i = 0; i < CH; i++) begin
            a[i] = ab[i][1];
            b[i] = ab[i][0];
        end
        clr = c;
        rst = r;
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("count%0d", i), 32'(count[i*W +: W]), 32'(mcount[i]));
            chk($sformatf("step%0d", i), 32'(step[i]), 32'(mstep[i]));
            chk($sformatf("dir%0d", i), 32'(dir[i]), 32'(mdir[i]));
            chk($sformatf("err%0d", i), 32'(err[i]), 32'(merr[i]));
        end
    endtask

    task automatic hold(input logic [1:0] ab0, input logic [1:0] ab1, input int nc);
        repeat (nc) cycle({ab1, ab0}, '0, 1'b0);
    endtask

    logic [1:0] rin [CH];
    int         rleft [CH];

    initial begin
        a = '0; b = '0; clr = '0; rst = 1'b1;

        // prime with 11 held through reset release: no step, no err
        repeat (3) cycle({2'b00, 2'b11}, '0, 1'b1);
        hold(2'b11, 2'b00, 10);
        chk("prime_cnt", 32'(count[W-1:0]), 0);

        // restart from 00, explicit latency check on the first forward step
        repeat (2) cycle({2'b00, 2'b00}, '0, 1'b1);
        hold(2'b00, 2'b00, 10);
        cycle({2'b00, 2'b01}, '0, 1'b0);
        for (int j = 1; j <= 5; j++) begin
            cycle({2'b00, 2'b01}, '0, 1'b0);
            chk($sformatf("lat%0d", j), 32'(step[0]), 32'(j == 5));
        end
        hold(2'b11, 2'b00, 8);
        hold(2'b10, 2'b00, 8);
        hold(2'b00, 2'b00, 8);
        chk("fwd4", 32'(count[W-1:0]), 4);
        hold(2'b10, 2'b00, 8);
        chk("rev3", 32'(count[W-1:0]), 3);
        chk("rev_dir", 32'(dir[0]), 0);

        // glitch on ch1 shorter than the filter
        hold(2'b10, 2'b01, 2);
        hold(2'b10, 2'b00, 10);
        chk("glitch", 32'(count[2*W-1:W]), 0);

        // illegal jump 10 -> 01 on ch0, then clear
        hold(2'b01, 2'b00, 8);
        chk("ill_err", 32'(err[0]), 1);
        chk("ill_cnt", 32'(count[W-1:0]), 3);
        cycle({2'b00, 2'b01}, 2'b01, 1'b0);
        hold(2'b01, 2'b00, 4);
        chk("clr_err", 32'(err[0]), 0);

        // clr coincident with a decoded step (01 -> 11 lands on edge k+5)
        cycle({2'b00, 2'b11}, '0, 1'b0);
        hold(2'b11, 2'b00, 4);
        cycle({2'b00, 2'b11}, 2'b01, 1'b0);
        chk("clr_step", 32'(step[0]), 0);
        hold(2'b11, 2'b00, 6);

        // wrap: one reverse step from 0, then 16 forward
        hold(2'b01, 2'b00, 8);
        chk("wrap_dn", 32'(count[W-1:0]), 15);
        for (int s = 0; s < 16; s++) hold(gv(2 + s), 2'b00, 6);
        chk("wrap_up", 32'(count[W-1:0]), 15);

        // concurrency: both forward together, then ch1 reverse while ch0 forward
        hold(gv(2), 2'b01, 6);
        hold(gv(3), 2'b11, 6);
        hold(gv(0), 2'b01, 6);

        // randomized walk with occasional illegal jumps, clears and a mid-run reset
        for (int c = 0; c < CH; c++) begin
            rin[c]   = {a[c], b[c]};
            rleft[c] = 0;
        end
        for (int i = 0; i < 1500; i++) begin
            logic [CH-1:0][1:0] ab;
            logic [CH-1:0]      cm;
            for (int c = 0; c < CH; c++) begin
                if (rleft[c] == 0) begin
                    int r;
                    r = $urandom_range(0, 19);
                    if (r < 8)       rin[c] = gv(gp(rin[c]) + 1);
                    else if (r < 16) rin[c] = gv(gp(rin[c]) + 3);
                    else if (r > 17) rin[c] = gv(gp(rin[c]) + 2);
                    rleft[c] = $urandom_range(1, 6);
                end
                rleft[c]--;
                ab[c] = rin[c];
                cm[c] = ($urandom_range(0, 49) == 0);
            end
            cycle(ab, cm, (i >= 800 && i < 802));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
